dresp_mem: RTL and testbench
============================

# dresp_mem

Data-port responder serving the CPU core's data bus (`o_addr_d`/`o_we_d`/`o_rd_d`/`o_data_out_d` in, `i_valid_d`/`i_data_in_d` out) from an external word-wide memory bus with a req/ack handshake. It stalls the core by holding `o_valid_d` low until an access is complete. It merges a held request so that one completion is never issued twice, and it bounds every bus transaction with a timeout. It sits between the core's MA stage and the memory/interconnect.

## Interface
- `TIMEOUT`, 256: cycles `o_mem_req` may stay unacknowledged before abort; 0 disables the timeout.
- `i_clk`  in  1  clock; everything is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_addr_d`  in  32  CPU byte address; only [31:2] is used.
- `i_we_d`  in  4  CPU byte-lane write enables; data is already lane-aligned.
- `i_rd_d`  in  1  CPU read request.
- `i_data_wr`  in  32  CPU write data.
- `o_valid_d`  out  1  access complete, or no access pending; drives the core's `i_valid_d`.
- `o_data_rd`  out  32  read data for the core's `i_data_in_d`; full word.
- `o_mem_req`  out  1  bus request, held until ack or timeout.
- `o_mem_addr`  out  30  word address.
- `o_mem_we`  out  4  byte enables; 0 means read.
- `o_mem_wdata`  out  32  write data.
- `i_mem_ack`  in  1  single-cycle ack; `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata`  in  32  bus read data.
- `o_bus_err`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- Access = `i_rd_d | (|i_we_d)`. If both `i_rd_d` and `i_we_d` are set, the write takes priority.
- No access: `o_valid_d`=1 combinationally. No bus activity is started.
- The key {addr[31:2], we, rd, wdata} is latched on every completion, and `held` is set.
  - While `held` is set and the key is unchanged, `o_valid_d`=1, `o_data_rd` shows the latched data, and no new bus access starts.
  - Any key change clears `held`.
  - Consequence: back-to-back identical accesses merge into one. This is intended; both reads and stores are idempotent.
- Sequencer FSM:
  - IDLE: a new, un-held access loads the bus registers, then → BUSY.
  - BUSY: `o_mem_req`=1.
    - On `i_mem_ack`: latch `i_mem_rdata` for reads, set `held`, → IDLE.
    - At TIMEOUT cycles without ack: drop the request, complete with data 32'hFFFF_FFFF, set `o_bus_err`, → IDLE.
- `i_mem_ack` is ignored in IDLE; stray and late acks have no effect.
- Timeout counter: reset on entry to BUSY; saturates; width is $clog2(TIMEOUT+1).
- Store completions leave `o_data_rd` unchanged.

## Timing
- Reset values:
  - `o_valid_d` follows the combinational rule above (1 when no access is presented).
  - `o_data_rd`=0, `o_mem_req`=0, `o_mem_addr`=0, `o_mem_we`=0, `o_mem_wdata`=0, `o_bus_err`=0.
  - FSM=IDLE, `held`=0, write buffer empty.
- Latency without posting, access first presented at cycle C0:
  - `o_mem_req` rises at C1.
  - An ack at C1+n gives `o_valid_d`=1 at C2+n.
  - Zero-wait memory gives 2 cycles of stall.
- Bus outputs are registered and stable while `o_mem_req`=1.
- Reset mid-transaction: `o_mem_req` drops on the next edge; a later ack is ignored.
- If the key changes while BUSY (not possible with a compliant core), the transaction still completes, and its result is discarded because the key mismatches.

## Configuration
- `DRESP_WBUF_EN` defined: a one-entry posted write buffer is added.
  - A new store with the buffer empty gets `o_valid_d`=1 in the same cycle. The buffer loads at that edge, `held` is set, and the sequencer drains the buffer in the background.
  - A store with the buffer full waits until it drains.
  - A read waits until the buffer is empty before launching; there is no forwarding.
  - A drain timeout sets `o_bus_err` and discards the entry.
- `DRESP_WBUF_EN` undefined: stores follow the read path and complete only on ack.

## Test plan
- Zero-wait read: `i_rd_d`=1, addr 0x100, ack at C1 with rdata 0xDEADBEEF -> `o_mem_addr`=0x40, `o_valid_d`=1 and `o_data_rd`=0xDEADBEEF at C2, with exactly one `o_mem_req` pulse.
- Wait states plus hold: store we=4'b0011 at 0x204, data 0x1234, ack after 3 cycles -> `o_valid_d` low for 5 cycles. The request then holds stable for 4 more cycles -> no second `o_mem_req`.
- Timeout: TIMEOUT=8, read with no ack -> request drops after 8 cycles, `o_data_rd`=0xFFFFFFFF, `o_bus_err`=1. A late ack afterwards has no effect.
- Reset mid-BUSY: assert `i_rst` 2 cycles into a request -> `o_mem_req`=0 next cycle, and an ack 1 cycle later is ignored.
- `DRESP_WBUF_EN`: store 0x300 then read 0x304, ack delayed 4 cycles -> store gets `o_valid_d`=1 at C0. The read's `o_mem_req` rises only after the write ack, and the read data is correct.

Source files
------------

// File: rtl/dresp_mem_if.sv
// Word-wide memory bus between dresp_mem and the memory/interconnect.
// req is held until a single-cycle ack; rdata is valid in the ack cycle.
// we == 0 marks a read, otherwise it carries byte-lane write enables.
interface dresp_mem_if;
  logic        req;
  logic [29:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  // Responder side: issues requests, receives ack and read data.
  modport master (
    output req, addr, we, wdata,
    input  ack, rdata
  );

  // Memory side: accepts requests, returns ack and read data.
  modport slave (
    input  req, addr, we, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dresp_mem.sv
// dresp_mem: data-port responder between the core's MA stage and a
// req/ack memory bus. Stalls the core by holding o_valid_d low until an
// access completes, merges a held (unchanged) request so that a completion
// is never issued twice, and aborts bus transactions after TIMEOUT cycles.
//
// Optional feature: define DRESP_WBUF_EN to add a one-entry posted write
// buffer. Stores then complete in the cycle they are presented (when the
// buffer is empty) and drain in the background; reads wait for the buffer
// to empty. Without the macro, stores take the same path as reads.
module dresp_mem #(
  parameter int unsigned TIMEOUT = 256  // 0 disables the timeout
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_addr_d,
  input  logic [3:0]         i_we_d,
  input  logic               i_rd_d,
  input  logic [31:0]        i_data_wr,
  output logic               o_valid_d,
  output logic [31:0]        o_data_rd,
  dresp_mem_if.master        mem,
  output logic               o_bus_err
);

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

  // Everything that identifies one core access; a change in any field is a
  // new access.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  we;
    logic        rd;
    logic [31:0] wdata;
  } key_t;

  // Counter wide enough to hold TIMEOUT; kept at one bit when disabled.
  localparam int unsigned    CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

  state_t       state_q;
  logic [CW-1:0] cnt_q;
  logic         req_q;
  logic [29:0]  addr_q;
  logic [3:0]   we_q;
  logic         rd_q;       // rd bit of the access in flight, for its key
  logic [31:0]  wdata_q;
  logic [31:0]  data_q;
  logic         err_q;
  logic         held_q;
  key_t         key_q;

`ifdef DRESP_WBUF_EN
  logic         wbuf_v_q;
  logic [29:0]  wbuf_addr_q;
  logic [3:0]   wbuf_we_q;
  logic [31:0]  wbuf_wdata_q;
  logic         drain_q;    // transaction in flight is a buffer drain
  logic         wr_accept;
  logic         launch_drain;
`endif

  logic         is_write;
  logic         access;
  key_t         cur_key;
  key_t         txn_key;
  logic         key_eq;
  logic         hit;
  logic         to_hit;
  logic         launch_direct;
  logic         unused_addr_lsbs;

  assign is_write = |i_we_d;
  assign access   = i_rd_d | is_write;
  assign cur_key  = {i_addr_d[31:2], i_we_d, i_rd_d, i_data_wr};
  assign txn_key  = {addr_q, we_q, rd_q, wdata_q};
  assign key_eq   = (key_q == cur_key);
  assign hit      = held_q && key_eq;

  // Byte offset is irrelevant on a word-wide bus.
  assign unused_addr_lsbs = ^i_addr_d[1:0];

  // Abort on the TIMEOUT-th unacknowledged request cycle; never when disabled.
  assign to_hit = (TIMEOUT != 0) && (state_q == S_BUSY) && !mem.ack
                  && (cnt_q == TO_LAST);

  // Completion status to the core and launch decisions for the sequencer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned; otherwise a latch is inferred.
    o_valid_d     = !access || hit;
    launch_direct = (state_q == S_IDLE) && access && !hit;
`ifdef DRESP_WBUF_EN
    wr_accept     = access && is_write && !hit && !wbuf_v_q;
    launch_drain  = (state_q == S_IDLE) && wbuf_v_q;
    o_valid_d     = !access || hit || (is_write && !wbuf_v_q);
    // Stores never go to the bus directly; reads wait for an empty buffer.
    launch_direct = (state_q == S_IDLE) && !wbuf_v_q && access && !is_write
                    && !hit;
`endif
  end

  // Sequencer, bus registers, merge key, read data and error flag.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      held_q  <= 1'b0;
      key_q   <= '0;
`ifdef DRESP_WBUF_EN
      wbuf_v_q     <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_we_q    <= '0;
      wbuf_wdata_q <= '0;
      drain_q      <= 1'b0;
`endif
    end else begin
      // Any change of the presented access ends the merge window.
      if (held_q && !key_eq) held_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
`ifdef DRESP_WBUF_EN
          if (launch_drain) begin
            addr_q  <= wbuf_addr_q;
            we_q    <= wbuf_we_q;
            rd_q    <= 1'b0;
            wdata_q <= wbuf_wdata_q;
            drain_q <= 1'b1;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= S_BUSY;
          end else
`endif
          if (launch_direct) begin
            addr_q  <= i_addr_d[31:2];
            we_q    <= i_we_d;
            rd_q    <= i_rd_d;
            wdata_q <= i_data_wr;
`ifdef DRESP_WBUF_EN
            drain_q <= 1'b0;
`endif
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (mem.ack || to_hit) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
            if (to_hit) err_q <= 1'b1;
`ifdef DRESP_WBUF_EN
            if (drain_q) begin
              // Drain done (or aborted): the entry is gone either way.
              wbuf_v_q <= 1'b0;
            end else
`endif
            if (txn_key == cur_key) begin
              // Result only counts if the core still presents this access.
              key_q  <= txn_key;
              held_q <= 1'b1;
              if (we_q == 4'b0000) data_q <= to_hit ? 32'hFFFF_FFFF : mem.rdata;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase

`ifdef DRESP_WBUF_EN
      // Posted store: complete now, drain later.
      if (wr_accept) begin
        wbuf_v_q     <= 1'b1;
        wbuf_addr_q  <= i_addr_d[31:2];
        wbuf_we_q    <= i_we_d;
        wbuf_wdata_q <= i_data_wr;
        key_q        <= cur_key;
        held_q       <= 1'b1;
      end
`endif
    end
  end

  assign o_data_rd = data_q;
  assign o_bus_err = err_q;
  assign mem.req   = req_q;
  assign mem.addr  = addr_q;
  assign mem.we    = we_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_dresp_mem.sv
// Directed testbench for dresp_mem with TIMEOUT=8. Each vector is one
// clock cycle: inputs are driven 1ns after the rising edge and outputs are
// compared on the falling edge.
module tb_dresp_mem;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_addr_d;
  logic [3:0]  i_we_d;
  logic        i_rd_d;
  logic [31:0] i_data_wr;
  logic        o_valid_d;
  logic [31:0] o_data_rd;
  logic        o_bus_err;

  dresp_mem_if mem_bus ();

  dresp_mem #(.TIMEOUT(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_addr_d  (i_addr_d),
    .i_we_d    (i_we_d),
    .i_rd_d    (i_rd_d),
    .i_data_wr (i_data_wr),
    .o_valid_d (o_valid_d),
    .o_data_rd (o_data_rd),
    .mem       (mem_bus),
    .o_bus_err (o_bus_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_valid;
    logic        e_req;
    logic        chk_bus;
    logic [29:0] e_maddr;
    logic [3:0]  e_mwe;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic rd, input logic [3:0] we,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic ack, input logic [31:0] rdata,
    input logic ev, input logic er, input logic cb,
    input logic [29:0] ema, input logic [3:0] emwe,
    input logic [31:0] ed, input logic ee);
    vec_t v;
    v.rst = rst; v.rd = rd; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ack = ack; v.rdata = rdata;
    v.e_valid = ev; v.e_req = er; v.chk_bus = cb;
    v.e_maddr = ema; v.e_mwe = emwe; v.e_data = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance.
  task automatic apply(input vec_t v, input string tag);
    i_rst         = v.rst;
    i_rd_d        = v.rd;
    i_we_d        = v.we;
    i_addr_d      = v.addr;
    i_data_wr     = v.wdata;
    mem_bus.ack   = v.ack;
    mem_bus.rdata = v.rdata;
    @(negedge i_clk);
    check({tag, " valid"},   32'(o_valid_d),   32'(v.e_valid));
    check({tag, " req"},     32'(mem_bus.req), 32'(v.e_req));
    check({tag, " data_rd"}, o_data_rd,        v.e_data);
    check({tag, " bus_err"}, 32'(o_bus_err),   32'(v.e_err));
    if (v.chk_bus) begin
      check({tag, " mem_addr"}, 32'(mem_bus.addr), 32'(v.e_maddr));
      check({tag, " mem_we"},   32'(mem_bus.we),   32'(v.e_mwe));
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset, zero-wait read, stray ack, wait-state store with hold.
    tbl.push_back(mk(1,0,4'h0,32'h0,32'h0,0,32'h0, 1,0,1,30'h0,4'h0,32'h0,0));
    tbl.push_back(mk(1,0,4'h0,32'h0,32'h0,0,32'h0, 1,0,1,30'h0,4'h0,32'h0,0));
    tbl.push_back(mk(0,0,4'h0,32'h0,32'h0,0,32'h0, 1,0,1,30'h0,4'h0,32'h0,0));
    tbl.push_back(mk(0,1,4'h0,32'h100,32'h0,0,32'h0,        0,0,1,30'h0, 4'h0,32'h0,0));
    tbl.push_back(mk(0,1,4'h0,32'h100,32'h0,1,32'hDEADBEEF, 0,1,1,30'h40,4'h0,32'h0,0));
    tbl.push_back(mk(0,1,4'h0,32'h100,32'h0,0,32'h0,        1,0,1,30'h40,4'h0,32'hDEADBEEF,0));
    tbl.push_back(mk(0,1,4'h0,32'h100,32'h0,0,32'h0,        1,0,1,30'h40,4'h0,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'h40,4'h0,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,4'h0,32'h0,32'h0,1,32'h12345678,   1,0,1,30'h40,4'h0,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'h40,4'h0,32'hDEADBEEF,0));
`ifndef DRESP_WBUF_EN
    tbl.push_back(mk(0,0,4'h3,32'h204,32'h1234,0,32'h0, 0,0,1,30'h40,4'h0,32'hDEADBEEF,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,4'h3,32'h204,32'h1234,0,32'h0, 0,1,1,30'h81,4'h3,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,4'h3,32'h204,32'h1234,1,32'h55555555, 0,1,1,30'h81,4'h3,32'hDEADBEEF,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,4'h3,32'h204,32'h1234,0,32'h0, 1,0,1,30'h81,4'h3,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,4'h0,32'h0,32'h0,0,32'h0, 1,0,1,30'h81,4'h3,32'hDEADBEEF,0));
`endif

    i_rst = 1'b1; i_rd_d = 1'b0; i_we_d = '0; i_addr_d = '0; i_data_wr = '0;
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Timeout: read with no ack, request for exactly 8 cycles, late ack ignored.
    apply(mk(0,1,4'h0,32'h400,32'h0,0,32'h0, 0,0,0,30'h0,4'h0,32'hDEADBEEF,0), "to c0");
    for (int i = 1; i <= 8; i++)
      apply(mk(0,1,4'h0,32'h400,32'h0,0,32'h0, 0,1,1,30'h100,4'h0,32'hDEADBEEF,0),
            $sformatf("to c%0d", i));
    apply(mk(0,1,4'h0,32'h400,32'h0,0,32'h0,        1,0,1,30'h100,4'h0,32'hFFFFFFFF,1), "to c9");
    apply(mk(0,1,4'h0,32'h400,32'h0,1,32'h11111111, 1,0,1,30'h100,4'h0,32'hFFFFFFFF,1), "to late ack");
    apply(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'h100,4'h0,32'hFFFFFFFF,1), "to idle");

    // Reset two cycles into a request; a following ack must be ignored.
    apply(mk(0,1,4'h0,32'h500,32'h0,0,32'h0,        0,0,1,30'h100,4'h0,32'hFFFFFFFF,1), "rst c0");
    apply(mk(0,1,4'h0,32'h500,32'h0,0,32'h0,        0,1,1,30'h140,4'h0,32'hFFFFFFFF,1), "rst c1");
    apply(mk(1,1,4'h0,32'h500,32'h0,0,32'h0,        0,1,1,30'h140,4'h0,32'hFFFFFFFF,1), "rst c2");
    apply(mk(0,0,4'h0,32'h0,32'h0,1,32'h77777777,   1,0,1,30'h0,4'h0,32'h0,0), "rst ack");
    apply(mk(0,1,4'h0,32'h500,32'h0,0,32'h0,        0,0,1,30'h0,4'h0,32'h0,0), "rst re c0");
    apply(mk(0,1,4'h0,32'h500,32'h0,1,32'hCAFEF00D, 0,1,1,30'h140,4'h0,32'h0,0), "rst re c1");
    apply(mk(0,1,4'h0,32'h500,32'h0,0,32'h0,        1,0,1,30'h140,4'h0,32'hCAFEF00D,0), "rst re c2");
    apply(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'h140,4'h0,32'hCAFEF00D,0), "rst idle");

    // Key change while BUSY: first result discarded, new access relaunched.
    apply(mk(0,1,4'h0,32'h600,32'h0,0,32'h0,        0,0,1,30'h140,4'h0,32'hCAFEF00D,0), "kc c0");
    apply(mk(0,1,4'h0,32'h604,32'h0,1,32'hBAD0BAD0, 0,1,1,30'h180,4'h0,32'hCAFEF00D,0), "kc c1");
    apply(mk(0,1,4'h0,32'h604,32'h0,0,32'h0,        0,0,1,30'h180,4'h0,32'hCAFEF00D,0), "kc c2");
    apply(mk(0,1,4'h0,32'h604,32'h0,1,32'h600D600D, 0,1,1,30'h181,4'h0,32'hCAFEF00D,0), "kc c3");
    apply(mk(0,1,4'h0,32'h604,32'h0,0,32'h0,        1,0,1,30'h181,4'h0,32'h600D600D,0), "kc c4");
    apply(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'h181,4'h0,32'h600D600D,0), "kc idle");

`ifdef DRESP_WBUF_EN
    // Posted store then read; drain acked after 4 wait cycles.
    apply(mk(0,0,4'hF,32'h300,32'hABCD0001,0,32'h0, 1,0,1,30'h181,4'h0,32'h600D600D,0), "wb c0");
    apply(mk(0,1,4'h0,32'h304,32'h0,0,32'h0,        0,0,1,30'h181,4'h0,32'h600D600D,0), "wb c1");
    for (int i = 2; i <= 5; i++)
      apply(mk(0,1,4'h0,32'h304,32'h0,0,32'h0, 0,1,1,30'hC0,4'hF,32'h600D600D,0),
            $sformatf("wb c%0d", i));
    apply(mk(0,1,4'h0,32'h304,32'h0,1,32'h99999999, 0,1,1,30'hC0,4'hF,32'h600D600D,0), "wb c6");
    apply(mk(0,1,4'h0,32'h304,32'h0,0,32'h0,        0,0,1,30'hC0,4'hF,32'h600D600D,0), "wb c7");
    apply(mk(0,1,4'h0,32'h304,32'h0,1,32'h13579BDF, 0,1,1,30'hC1,4'h0,32'h600D600D,0), "wb c8");
    apply(mk(0,1,4'h0,32'h304,32'h0,0,32'h0,        1,0,1,30'hC1,4'h0,32'h13579BDF,0), "wb c9");
    apply(mk(0,0,4'h0,32'h0,32'h0,0,32'h0,          1,0,1,30'hC1,4'h0,32'h13579BDF,0), "wb idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
